// File: rtl/tx_huge_page_sched_pkg.sv
// Shared types and constants for the huge-page TX read scheduler.
// Holds the FSM encoding, default request cap and 4 KB boundary geometry.
package tx_huge_page_sched_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FREE  = 3'd3,
    ST_CMPL  = 3'd4
  } sched_state_t;

  localparam int DEF_MAX_RD_QW = 64;
  localparam int PAGE_4K_BYTES = 4096;
  localparam int QW_BYTES      = 8;
  localparam int PAGE_4K_QW    = PAGE_4K_BYTES / QW_BYTES;
  localparam int RD_LEN_W      = 10;

  function automatic logic [RD_LEN_W-1:0] min_len(input logic [RD_LEN_W-1:0] a,
                                                  input logic [RD_LEN_W-1:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/tx_rd_chunk_calc.sv
// Next read length: min(remaining, MAX_RD_QW, qwords left before the 4 KB line).
// Purely combinational; zero when nothing remains.
module tx_rd_chunk_calc
  import tx_huge_page_sched_pkg::*;
#(
  parameter int MAX_RD_QW = DEF_MAX_RD_QW
) (
  input  logic [8:0]          addr_qw,
  input  logic [31:0]         remaining,
  output logic [RD_LEN_W-1:0] chunk_qwords
);

  localparam logic [RD_LEN_W-1:0] MAX_QW_L  = RD_LEN_W'(MAX_RD_QW);
  localparam logic [RD_LEN_W-1:0] PAGE_QW_L = RD_LEN_W'(PAGE_4K_QW);

  logic [RD_LEN_W-1:0] rem_clip;
  logic [RD_LEN_W-1:0] to_boundary;

  always_comb begin
    rem_clip     = (remaining > 32'(MAX_RD_QW)) ? MAX_QW_L : remaining[RD_LEN_W-1:0];
    // addr_qw is the qword index inside the 4 KB page, so this is 1..512
    to_boundary  = PAGE_QW_L - {1'b0, addr_qw};
    chunk_qwords = min_len(rem_clip, to_boundary);
  end

endmodule

// File: rtl/tx_huge_page_sched.sv
// Ping-pong huge-page scheduler: splits each page into 4 KB-safe read requests,
// caps requests in flight, then frees the page and posts its completion.
module tx_huge_page_sched
  import tx_huge_page_sched_pkg::*;
#(
  parameter int MAX_RD_QW       = DEF_MAX_RD_QW,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                trn_clk,
  input  logic                reset_n,
  input  logic [63:0]         huge_page_addr_1,
  input  logic [63:0]         huge_page_addr_2,
  input  logic [31:0]         huge_page_qwords_1,
  input  logic [31:0]         huge_page_qwords_2,
  input  logic                huge_page_status_1,
  input  logic                huge_page_status_2,
  output logic                huge_page_free_1,
  output logic                huge_page_free_2,
  output logic                rd_req_valid,
  input  logic                rd_req_ready,
  output logic [63:0]         rd_req_addr,
  output logic [RD_LEN_W-1:0] rd_req_qwords,
  input  logic                rd_done,
  output logic                cmpl_req_valid,
  output logic                cmpl_req_page,
  input  logic                cmpl_ack
);

  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam logic [OW-1:0] MAX_OUT_L = OW'(MAX_OUTSTANDING);
  localparam logic [OW-1:0] ONE_L     = OW'(1);

  sched_state_t        state;
  logic                turn;
  logic [63:0]         cur_addr;
  logic [31:0]         remaining;
  logic [OW-1:0]       outstanding;
  logic [RD_LEN_W-1:0] chunk_qw;
  logic [31:0]         rem_after;
  logic                accept;
  logic                done_eff;
  logic                sel_status;
  logic [63:0]         sel_addr;
  logic [31:0]         sel_qwords;

  tx_rd_chunk_calc #(
    .MAX_RD_QW    (MAX_RD_QW)
  ) u_chunk (
    .addr_qw      (cur_addr[11:3]),
    .remaining    (remaining),
    .chunk_qwords (chunk_qw)
  );

  // Request fields come straight from state registers, so they hold while stalled
  assign rd_req_valid  = (state == ST_ISSUE) && (remaining != '0) && (outstanding < MAX_OUT_L);
  assign rd_req_addr   = cur_addr;
  assign rd_req_qwords = chunk_qw;

  assign accept    = rd_req_valid && rd_req_ready;
  assign done_eff  = rd_done && (outstanding != '0);
  assign rem_after = remaining - 32'(chunk_qw);

  assign sel_status = turn ? huge_page_status_2 : huge_page_status_1;
  assign sel_addr   = turn ? huge_page_addr_2   : huge_page_addr_1;
  assign sel_qwords = turn ? huge_page_qwords_2 : huge_page_qwords_1;

  always_ff @(posedge trn_clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= ST_IDLE;
      turn             <= 1'b0;
      cur_addr         <= '0;
      remaining        <= '0;
      outstanding      <= '0;
      huge_page_free_1 <= 1'b0;
      huge_page_free_2 <= 1'b0;
      cmpl_req_valid   <= 1'b0;
      cmpl_req_page    <= 1'b0;
    end else begin
      huge_page_free_1 <= 1'b0;
      huge_page_free_2 <= 1'b0;

      if (accept && !done_eff) begin
        outstanding <= outstanding + ONE_L;
      end else if (!accept && done_eff) begin
        outstanding <= outstanding - ONE_L;
      end

      case (state)
        ST_IDLE: begin
          if (sel_status) begin
            cur_addr  <= sel_addr;
            remaining <= sel_qwords;
            if (sel_qwords == '0) begin
              state            <= ST_FREE;
              huge_page_free_1 <= ~turn;
              huge_page_free_2 <= turn;
            end else begin
              state <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (accept) begin
            cur_addr  <= cur_addr + (64'(chunk_qw) << 3);
            remaining <= rem_after;
            if (rem_after == '0) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (outstanding == '0) begin
            state            <= ST_FREE;
            huge_page_free_1 <= ~turn;
            huge_page_free_2 <= turn;
          end
        end
        ST_FREE: begin
          state          <= ST_CMPL;
          cmpl_req_valid <= 1'b1;
          cmpl_req_page  <= turn;
        end
        ST_CMPL: begin
          if (cmpl_ack) begin
            cmpl_req_valid <= 1'b0;
            turn           <= ~turn;
            state          <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_huge_page_sched.sv
// Directed bench for tx_huge_page_sched: hand-computed request streams,
// free pulses and completion pages for each scenario.
module tb_tx_huge_page_sched;

  logic        trn_clk;
  logic        reset_n;
  logic [63:0] huge_page_addr_1, huge_page_addr_2;
  logic [31:0] huge_page_qwords_1, huge_page_qwords_2;
  logic        huge_page_status_1, huge_page_status_2;
  logic        huge_page_free_1, huge_page_free_2;
  logic        rd_req_valid, rd_req_ready;
  logic [63:0] rd_req_addr;
  logic [9:0]  rd_req_qwords;
  logic        rd_done;
  logic        cmpl_req_valid, cmpl_req_page, cmpl_ack;

  int          n_checks, n_pass;
  int          acc_cnt, free1_cnt, free2_cnt, valid_cycles, pending;
  logic [63:0] acc_addr [64];
  logic [9:0]  acc_qw   [64];
  logic        done_en, done_kick;

  tx_huge_page_sched dut (
    .trn_clk            (trn_clk),
    .reset_n            (reset_n),
    .huge_page_addr_1   (huge_page_addr_1),
    .huge_page_addr_2   (huge_page_addr_2),
    .huge_page_qwords_1 (huge_page_qwords_1),
    .huge_page_qwords_2 (huge_page_qwords_2),
    .huge_page_status_1 (huge_page_status_1),
    .huge_page_status_2 (huge_page_status_2),
    .huge_page_free_1   (huge_page_free_1),
    .huge_page_free_2   (huge_page_free_2),
    .rd_req_valid       (rd_req_valid),
    .rd_req_ready       (rd_req_ready),
    .rd_req_addr        (rd_req_addr),
    .rd_req_qwords      (rd_req_qwords),
    .rd_done            (rd_done),
    .cmpl_req_valid     (cmpl_req_valid),
    .cmpl_req_page      (cmpl_req_page),
    .cmpl_ack           (cmpl_ack)
  );

  initial begin
    trn_clk = 1'b0;
    forever #5 trn_clk = ~trn_clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // rd_done responder (driven after posedge) and request monitor (sampled at negedge)
  initial begin
    rd_done = 1'b0;
    forever begin
      @(posedge trn_clk);
      #1;
      if (done_kick) begin
        rd_done   = 1'b1;
        done_kick = 1'b0;
        if (pending > 0) pending--;
      end else if (done_en && pending > 0) begin
        rd_done = 1'b1;
        pending--;
      end else begin
        rd_done = 1'b0;
      end
      @(negedge trn_clk);
      if (rd_req_valid) valid_cycles++;
      if (rd_req_valid && rd_req_ready) begin
        if (acc_cnt < 64) begin
          acc_addr[acc_cnt] = rd_req_addr;
          acc_qw[acc_cnt]   = rd_req_qwords;
        end
        acc_cnt++;
        pending++;
      end
      if (huge_page_free_1) free1_cnt++;
      if (huge_page_free_2) free2_cnt++;
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge trn_clk);
      #1;
    end
  endtask

  task automatic clear_counts();
    acc_cnt = 0; free1_cnt = 0; free2_cnt = 0; valid_cycles = 0;
  endtask

  task automatic wait_cmpl(input string tag);
    int n;
    n = 0;
    @(negedge trn_clk);
    while (!cmpl_req_valid && n < 600) begin
      @(negedge trn_clk);
      n++;
    end
    check(tag, 64'(cmpl_req_valid), 64'd1);
  endtask

  task automatic ack_cmpl(input string tag);
    @(posedge trn_clk);
    #1 cmpl_ack = 1'b1;
    @(posedge trn_clk);
    #1 cmpl_ack = 1'b0;
    check(tag, 64'(cmpl_req_valid), 64'd0);
  endtask

  initial begin
    n_checks = 0; n_pass = 0; pending = 0;
    done_en = 1'b0; done_kick = 1'b0;
    clear_counts();
    reset_n = 1'b0;
    huge_page_addr_1 = '0; huge_page_addr_2 = '0;
    huge_page_qwords_1 = '0; huge_page_qwords_2 = '0;
    huge_page_status_1 = 1'b0; huge_page_status_2 = 1'b0;
    rd_req_ready = 1'b0; cmpl_ack = 1'b0;
    #2;
    check("rst_valid",  64'(rd_req_valid),     64'd0);
    check("rst_free1",  64'(huge_page_free_1), 64'd0);
    check("rst_free2",  64'(huge_page_free_2), 64'd0);
    check("rst_cmpl",   64'(cmpl_req_valid),   64'd0);
    check("rst_page",   64'(cmpl_req_page),    64'd0);
    check("rst_addr",   rd_req_addr,           64'd0);
    check("rst_qw",     64'(rd_req_qwords),    64'd0);
    tick(3);
    reset_n = 1'b1;
    tick(2);

    // Page 1: 200 qwords above 4 GB -> 64/64/64/8; status dropped mid-page
    clear_counts();
    huge_page_addr_1 = 64'h1_0000_0000; huge_page_qwords_1 = 32'd200;
    rd_req_ready = 1'b1; done_en = 1'b1; huge_page_status_1 = 1'b1;
    tick(3);
    huge_page_status_1 = 1'b0;
    wait_cmpl("a_cmpl");
    check("a_nreq",  64'(acc_cnt),   64'd4);
    check("a_addr0", acc_addr[0],    64'h1_0000_0000);
    check("a_qw0",   64'(acc_qw[0]), 64'd64);
    check("a_addr1", acc_addr[1],    64'h1_0000_0200);
    check("a_qw1",   64'(acc_qw[1]), 64'd64);
    check("a_addr2", acc_addr[2],    64'h1_0000_0400);
    check("a_qw2",   64'(acc_qw[2]), 64'd64);
    check("a_addr3", acc_addr[3],    64'h1_0000_0600);
    check("a_qw3",   64'(acc_qw[3]), 64'd8);
    check("a_free1", 64'(free1_cnt), 64'd1);
    check("a_free2", 64'(free2_cnt), 64'd0);
    check("a_page",  64'(cmpl_req_page), 64'd0);
    ack_cmpl("a_ack");

    // Page 2: 64 qwords at 0xFC0 -> 8 before the 4 KB line, 56 after
    clear_counts();
    huge_page_addr_2 = 64'h0FC0; huge_page_qwords_2 = 32'd64; huge_page_status_2 = 1'b1;
    wait_cmpl("b_cmpl");
    huge_page_status_2 = 1'b0;
    check("b_nreq",  64'(acc_cnt),   64'd2);
    check("b_addr0", acc_addr[0],    64'h0FC0);
    check("b_qw0",   64'(acc_qw[0]), 64'd8);
    check("b_addr1", acc_addr[1],    64'h1000);
    check("b_qw1",   64'(acc_qw[1]), 64'd56);
    check("b_free2", 64'(free2_cnt), 64'd1);
    check("b_free1", 64'(free1_cnt), 64'd0);
    check("b_page",  64'(cmpl_req_page), 64'd1);
    ack_cmpl("b_ack");

    // Stray rd_done while nothing is in flight must not underflow
    done_kick = 1'b1;
    tick(3);

    // Page 1: 2000 qwords, rd_done withheld -> capped at 4 in flight
    clear_counts();
    done_en = 1'b0;
    huge_page_addr_1 = 64'h2000; huge_page_qwords_1 = 32'd2000; huge_page_status_1 = 1'b1;
    tick(20);
    check("c_cap_nreq",  64'(acc_cnt),      64'd4);
    check("c_cap_valid", 64'(rd_req_valid), 64'd0);
    done_kick = 1'b1;
    tick(5);
    check("c_one_more",  64'(acc_cnt),      64'd5);
    done_en = 1'b1;
    wait_cmpl("c_cmpl");
    huge_page_status_1 = 1'b0;
    check("c_nreq",   64'(acc_cnt),    64'd32);
    check("c_addr8",  acc_addr[8],     64'h3000);
    check("c_addr31", acc_addr[31],    64'h5E00);
    check("c_qw31",   64'(acc_qw[31]), 64'd16);
    check("c_page",   64'(cmpl_req_page), 64'd0);
    ack_cmpl("c_ack");

    // Page 2 stalled in ISSUE, then reset mid-page
    clear_counts();
    done_en = 1'b0; rd_req_ready = 1'b0;
    huge_page_addr_2 = 64'h7000; huge_page_qwords_2 = 32'd1000; huge_page_status_2 = 1'b1;
    tick(2);
    check("r_valid",  64'(rd_req_valid),  64'd1);
    check("r_addr",   rd_req_addr,        64'h7000);
    check("r_qw",     64'(rd_req_qwords), 64'd64);
    tick(3);
    check("r_hold_valid", 64'(rd_req_valid),  64'd1);
    check("r_hold_addr",  rd_req_addr,        64'h7000);
    check("r_hold_qw",    64'(rd_req_qwords), 64'd64);
    @(negedge trn_clk);
    #2 reset_n = 1'b0;
    #1;
    check("r_rst_valid", 64'(rd_req_valid),     64'd0);
    check("r_rst_addr",  rd_req_addr,           64'd0);
    check("r_rst_qw",    64'(rd_req_qwords),    64'd0);
    check("r_rst_free2", 64'(huge_page_free_2), 64'd0);
    check("r_rst_cmpl",  64'(cmpl_req_valid),   64'd0);
    huge_page_status_2 = 1'b0;
    tick(2);
    reset_n = 1'b1;
    pending = 0;
    tick(4);
    check("r_no_free", 64'(free1_cnt + free2_cnt), 64'd0);
    check("r_no_cmpl", 64'(cmpl_req_valid),        64'd0);

    // Both statuses together: page 1 first (turn reset), page 2 only after ack
    clear_counts();
    rd_req_ready = 1'b1; done_en = 1'b1;
    huge_page_addr_1 = 64'h3000; huge_page_qwords_1 = 32'd10;
    huge_page_addr_2 = 64'h4000; huge_page_qwords_2 = 32'd20;
    huge_page_status_1 = 1'b1; huge_page_status_2 = 1'b1;
    wait_cmpl("d1_cmpl");
    check("d1_page",  64'(cmpl_req_page), 64'd0);
    check("d1_nreq",  64'(acc_cnt),       64'd1);
    check("d1_addr",  acc_addr[0],        64'h3000);
    check("d1_qw",    64'(acc_qw[0]),     64'd10);
    check("d1_free1", 64'(free1_cnt),     64'd1);
    check("d1_free2", 64'(free2_cnt),     64'd0);
    tick(5);
    check("d1_wait_ack", 64'(acc_cnt),    64'd1);
    ack_cmpl("d1_ack");
    clear_counts();
    wait_cmpl("d2_cmpl");
    huge_page_status_1 = 1'b0; huge_page_status_2 = 1'b0;
    check("d2_page",  64'(cmpl_req_page), 64'd1);
    check("d2_nreq",  64'(acc_cnt),       64'd1);
    check("d2_addr",  acc_addr[0],        64'h4000);
    check("d2_qw",    64'(acc_qw[0]),     64'd20);
    check("d2_free2", 64'(free2_cnt),     64'd1);
    check("d2_free1", 64'(free1_cnt),     64'd0);
    ack_cmpl("d2_ack");

    // Page 1 with zero qwords: no request, single free pulse
    clear_counts();
    huge_page_addr_1 = 64'h9000; huge_page_qwords_1 = 32'd0; huge_page_status_1 = 1'b1;
    wait_cmpl("e_cmpl");
    huge_page_status_1 = 1'b0;
    check("e_valid_cycles", 64'(valid_cycles),  64'd0);
    check("e_free1",        64'(free1_cnt),     64'd1);
    check("e_page",         64'(cmpl_req_page), 64'd0);
    ack_cmpl("e_ack");

    // Page 2 straddling 4 GB: carry into bit 32
    clear_counts();
    huge_page_addr_2 = 64'h0000_0000_FFFF_FF00; huge_page_qwords_2 = 32'd64;
    huge_page_status_2 = 1'b1;
    wait_cmpl("g_cmpl");
    huge_page_status_2 = 1'b0;
    check("g_nreq",  64'(acc_cnt),   64'd2);
    check("g_addr0", acc_addr[0],    64'h0000_0000_FFFF_FF00);
    check("g_qw0",   64'(acc_qw[0]), 64'd32);
    check("g_addr1", acc_addr[1],    64'h0000_0001_0000_0000);
    check("g_qw1",   64'(acc_qw[1]), 64'd32);
    check("g_page",  64'(cmpl_req_page), 64'd1);
    ack_cmpl("g_ack");

    tick(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
